// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, the NOP
// word substituted for rejected requests, immediate range limits and the
// immediate decode used to recover in_imm from an encoded word.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_I    = 2'd0,
    FMT_S    = 2'd1,
    FMT_B    = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // 12-bit signed immediate (I/S) and 13-bit even branch offset (B)
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;

  // One buffer entry: error flag on top of the 32-bit word
  localparam int ENTRY_W = 33;

  // Reassemble the sign-extended immediate scattered through an encoded word
  function automatic logic signed [31:0] imm_decode(input fmt_e fmt, input logic [31:0] w);
    logic signed [31:0] r;
    case (fmt)
      FMT_I:   r = {{20{w[31]}}, w[31:20]};
      FMT_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Output buffer for the encoder: DEPTH entries of {err, word}, in-order,
// power-of-two depth so both pointers wrap naturally. Only control state
// (pointers, occupancy) is reset; entry storage is qualified by occupancy.
module instr_enc_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             not_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign not_full  = (count < FULL_C);
  assign not_empty = (count != '0);
  assign do_push   = push & not_full;
  assign do_pop    = pop & not_empty;
  assign head      = mem[rptr];

  // Pointer and occupancy tracking; push+pop together leaves occupancy alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the accepting edge
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes I/S/B-type field sets into 32-bit instruction words. Encoding and
// range checks are combinational on the request; the result (or NOP with
// the error flag) is buffered in order and presented with valid/ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  function automatic logic out_of_range(input logic signed [31:0] v,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return (v < lo) || (v > hi);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [31:0]   imm_s_p0;
  logic [31:0]          word_p0;
  logic                 err_p0;
  logic                 push;
  logic                 pop;
  logic                 head_vld;
  logic [ENTRY_W-1:0]   head;

  assign imm_s_p0 = signed'(in_imm);

  // Field packing and immediate legality for the presented request
  always_comb begin
    err_p0  = 1'b0;
    word_p0 = NOP;
    case (fmt_e'(in_fmt))
      FMT_I: begin
        err_p0  = out_of_range(imm_s_p0, IMM12_MIN, IMM12_MAX);
        word_p0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        err_p0  = out_of_range(imm_s_p0, IMM12_MIN, IMM12_MAX);
        word_p0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        err_p0  = out_of_range(imm_s_p0, IMMB_MIN, IMMB_MAX) || in_imm[0];
        word_p0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
      end
      default: err_p0 = 1'b1;
    endcase
    if (err_p0) word_p0 = NOP;
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // ---- buffer stage: accepted request stored at the accepting edge ----
  instr_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({err_p0, word_p0}),
    .pop       (pop),
    .head      (head),
    .not_empty (head_vld),
    .not_full  (in_ready)
  );

  // Outputs read zero whenever no entry is presented
  assign out_valid = head_vld;
  assign out_instr = head_vld ? head[31:0] : 32'h0;
  assign out_err   = head_vld & head[32];

  // Count successful encodes, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (push && !err_p0) begin
      enc_count <= sat_inc16(enc_count);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model with a per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_fmt = 2'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  fmt;
    int          imm;
  } ent_t;

  ent_t q[$];
  int   mcount = 0;
  int   bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, -4095};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the format rules, using integer ranges
  function automatic ent_t model_enc(input logic [1:0] f, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [31:0] imm);
    ent_t e;
    int v;
    v = int'(signed'(imm));
    e.fmt = f;
    e.imm = v;
    e.err = 1'b0;
    e.instr = 32'h13;
    if (f == 2'd0) begin
      if (v < -2048 || v > 2047) e.err = 1'b1;
      else e.instr = {imm[11:0], rs1, f3, rd, op};
    end else if (f == 2'd1) begin
      if (v < -2048 || v > 2047) e.err = 1'b1;
      else e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    end else if (f == 2'd2) begin
      if (v < -4096 || v > 4094 || (v % 2) != 0) e.err = 1'b1;
      else e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Model state: a bounded in-order queue plus a saturating success counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mcount = 0;
    end else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && out_ready;
      e = model_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
      if (do_pop) q.delete(0);
      if (do_push) begin
        q.push_back(e);
        if (!e.err && mcount < 65535) mcount++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("enc_count", {16'd0, enc_count}, 32'(mcount));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
      if (!q[0].err)
        chk("imm_decode", imm_decode(fmt_e'(q[0].fmt), out_instr), 32'(q[0].imm));
    end else begin
      chk("idle_instr", out_instr, 32'h0);
      chk("idle_err", {31'd0, out_err}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input int imm);
    int   n;
    logic acc;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = 32'(imm); in_valid = 1'b1;
    n = 0;
    forever begin
      acc = in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in_ready actual=0 required=1 at %0t", $time);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed encodes with literal expectations
    out_ready = 1'b1;
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 5);
    chk("i_basic_instr", out_instr, 32'h0050_0093);
    chk("i_basic_err", {31'd0, out_err}, 32'd0);
    chk("i_basic_count", {16'd0, enc_count}, 32'd1);
    send(FMT_S, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, -4);
    chk("s_basic_instr", out_instr, 32'hFE21_AE23);
    chk("s_basic_count", {16'd0, enc_count}, 32'd2);
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -8);
    chk("b_basic_instr", out_instr, 32'hFE20_8CE3);
    chk("b_basic_err", {31'd0, out_err}, 32'd0);
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 3);
    chk("b_odd_err", {31'd0, out_err}, 32'd1);
    chk("b_odd_instr", out_instr, 32'h0000_0013);
    chk("b_odd_count", {16'd0, enc_count}, 32'd3);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2048);
    chk("i_2048_err", {31'd0, out_err}, 32'd1);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -2049);
    chk("i_m2049_err", {31'd0, out_err}, 32'd1);
    chk("i_oor_count", {16'd0, enc_count}, 32'd3);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2047);
    chk("i_2047_err", {31'd0, out_err}, 32'd0);
    chk("i_2047_instr", out_instr, 32'h7FF0_0093);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -2048);
    chk("i_m2048_err", {31'd0, out_err}, 32'd0);
    chk("i_m2048_instr", out_instr, 32'h8000_0093);
    send(FMT_RSVD, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 0);
    chk("rsvd_err", {31'd0, out_err}, 32'd1);
    chk("edge_count", {16'd0, enc_count}, 32'd5);
    step();
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill, hold a third request, then drain in order
    out_ready = 1'b0;
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2);
    in_imm = 32'd3; in_valid = 1'b1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    chk("held_head", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    step();
    chk("order_b", out_instr, 32'h0020_0093);
    chk("order_b_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("order_c", out_instr, 32'h0030_0093);
    chk("pushpop_valid", {31'd0, out_valid}, 32'd1);
    chk("pushpop_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_count", {16'd0, enc_count}, 32'd8);

    // Reset mid-cycle with two entries buffered
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 4);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #4 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {16'd0, enc_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_instr", out_instr, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7);
    chk("post_rst_first", out_instr, 32'h0070_0093);
    chk("post_rst_count", {16'd0, enc_count}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    // Randomized traffic, with one asynchronous reset partway through
    for (int i = 0; i < 3000; i++) begin
      int v;
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 8191)) - 4096;
        1:       v = bnd[$urandom_range(0, 9)];
        2:       v = int'($urandom);
        default: v = (int'($urandom_range(0, 255)) - 128) * 2;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fmt    = 2'($urandom_range(0, 3));
      in_opcode = 7'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_imm    = 32'(v);
      out_ready = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
